multdiv_ctrl: RTL and testbench

//  Sequencer for the shared iterative multiply/divide datapath in the processor execute stage.
//  - Accepts single-cycle ctrl_MULT / ctrl_DIV start pulses.
//  - Drives the datapath load strobe (counter_zero) and mode select, and counts iterations.
//  - Latches the result and flags; raises a one-cycle ready pulse; drives busy to stall the pipeline.

---
 rtl/multdiv_ctrl.sv | 91 +++++++++
 tb/tb_multdiv_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared iterative multiply/divide datapath: start decode, load strobe,
// iteration counting, result/exception capture and the one-cycle ready pulse.
module multdiv_ctrl #(
   parameter int DIV_ITERS  = 32,
   parameter int MULT_ITERS = 16,
   parameter int CNT_W      = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [31:0]      data_operandB,
   input  logic [31:0]      dp_result,
   input  logic             dp_ovf,
   output logic             counter_zero,
   output logic             dp_sel_div,
   output logic [31:0]      data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy,
   output logic [CNT_W-1:0] iter_count
);

   // state  | meaning
   // S_IDLE | waiting for a start pulse
   // S_LOAD | datapath loads operands (counter_zero high)
   // S_RUN  | datapath iterating, iter_count counts 0..N-1
   // S_DONE | result valid, data_resultRDY high for one cycle
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t           state, state_nxt;
   logic             op_div;
   logic             start, start_div, div_zero, last_iter;
   logic [CNT_W-1:0] iter_last;

   // Multiply has priority when both pulses arrive together.
   assign start     = ctrl_MULT | ctrl_DIV;
   assign start_div = ctrl_DIV & ~ctrl_MULT;
   assign div_zero  = start_div & (data_operandB == 32'd0);
   assign iter_last = op_div ? CNT_W'(DIV_ITERS - 1) : CNT_W'(MULT_ITERS - 1);
   assign last_iter = (state == S_RUN) && (iter_count == iter_last);

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = div_zero ? S_DONE : S_LOAD;
      end else begin
         case (state)
            S_IDLE:  state_nxt = S_IDLE;
            S_LOAD:  state_nxt = S_RUN;
            S_RUN:   state_nxt = last_iter ? S_DONE : S_RUN;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= S_IDLE;
         op_div         <= 1'b0;
         iter_count     <= '0;
         data_result    <= 32'd0;
         data_exception <= 1'b0;
      end else begin
         state <= state_nxt;
         // A start in any state aborts whatever was running and restarts.
         if (start) begin
            op_div         <= start_div;
            iter_count     <= '0;
            data_exception <= div_zero;
            if (div_zero) begin
               data_result <= 32'd0;
            end
         end else if (state == S_RUN) begin
            if (last_iter) begin
               data_result    <= dp_result;
               data_exception <= ~op_div & dp_ovf;
            end else begin
               iter_count <= iter_count + 1'b1;
            end
         end
      end
   end

   assign counter_zero   = (state == S_LOAD);
   assign busy           = (state == S_LOAD) || (state == S_RUN);
   assign data_resultRDY = (state == S_DONE);
   assign dp_sel_div     = op_div;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: expected results are queued at each start and
// compared when the ready pulse is due; control outputs are checked every cycle.
module tb_multdiv_ctrl;

   logic        clock = 1'b0;
   logic        reset, ctrl_MULT, ctrl_DIV, dp_ovf;
   logic [31:0] data_operandB, dp_result;
   logic        counter_zero, dp_sel_div, data_exception, data_resultRDY, busy;
   logic [31:0] data_result;
   logic [5:0]  iter_count;

   multdiv_ctrl #(.DIV_ITERS(32), .MULT_ITERS(16), .CNT_W(6)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandB  (data_operandB),
      .dp_result      (dp_result),
      .dp_ovf         (dp_ovf),
      .counter_zero   (counter_zero),
      .dp_sel_div     (dp_sel_div),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy),
      .iter_count     (iter_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          load_c   = 0;
   int          done_c   = 0;
   int          nits     = 16;
   bit          active   = 1'b0;
   bit          bz_op    = 1'b0;
   bit          exp_sel  = 1'b0;
   logic [31:0] res_hold = 32'd0;
   logic        exc_hold = 1'b0;
   logic [31:0] last_res = 32'd0;
   logic        last_ovf = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // One clock: drive the datapath model, advance, then check every output.
   task automatic step();
      exp_t e;
      int   exp_iter;
      if (active && !bz_op && cyc == done_c - 1) begin
         dp_result = last_res;
         dp_ovf    = last_ovf;
      end else begin
         dp_result = $urandom;
         dp_ovf    = 1'($urandom_range(0, 1));
      end
      @(posedge clock);
      #1;
      cyc++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         check_val("rdy", 32'(data_resultRDY), 32'd1);
         res_hold = e.res;
         exc_hold = e.exc;
      end else begin
         check_val("no_rdy", 32'(data_resultRDY), 32'd0);
      end
      check_val("result", data_result, res_hold);
      check_val("exception", 32'(data_exception), 32'(exc_hold));
      check_val("busy", 32'(busy), 32'(active && cyc >= load_c && cyc < done_c));
      check_val("counter_zero", 32'(counter_zero), 32'(active && !bz_op && cyc == load_c));
      check_val("dp_sel_div", 32'(dp_sel_div), 32'(exp_sel));
      if (!bz_op) begin
         if (!active || cyc <= load_c + 1) exp_iter = 0;
         else if (cyc - load_c - 1 < nits - 1) exp_iter = cyc - load_c - 1;
         else exp_iter = nits - 1;
         check_val("iter_count", 32'(iter_count), 32'(exp_iter));
      end
   endtask

   task automatic start_op(input bit m, input bit d, input logic [31:0] b,
                           input logic [31:0] res, input logic ovf);
      exp_t e;
      bit   is_div;
      is_div        = d && !m;
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandB = b;
      sb.delete();
      active  = 1'b1;
      exp_sel = is_div;
      bz_op   = is_div && (b == 32'd0);
      nits    = is_div ? 32 : 16;
      load_c  = cyc + 1;
      if (bz_op) begin
         done_c = cyc + 1;
         e.res  = 32'd0;
         e.exc  = 1'b1;
      end else begin
         done_c   = cyc + nits + 2;
         e.res    = res;
         e.exc    = !is_div && ovf;
         exc_hold = 1'b0;
      end
      last_res = res;
      last_ovf = ovf;
      e.due    = done_c;
      sb.push_back(e);
      step();
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandB = $urandom;
   endtask

   task automatic do_reset(input int n);
      reset    = 1'b1;
      active   = 1'b0;
      bz_op    = 1'b0;
      exp_sel  = 1'b0;
      res_hold = 32'd0;
      exc_hold = 1'b0;
      sb.delete();
      repeat (n) step();
      reset = 1'b0;
   endtask

   task automatic run_until(input int t);
      while (cyc < t) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset         = 1'b1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandB = 32'd0;
      dp_result     = 32'd0;
      dp_ovf        = 1'b0;
      do_reset(2);
      run_until(cyc + 3);

      // Divide 100/7; ovf forced high in the last cycle must be ignored for DIV.
      start_op(1'b0, 1'b1, 32'd7, 32'd14, 1'b1);
      run_until(done_c + 1);

      // Multiply -3*5, then a div-by-zero start issued in the DONE cycle.
      start_op(1'b1, 1'b0, 32'd5, 32'hFFFF_FFF1, 1'b0);
      run_until(done_c);
      start_op(1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
      run_until(cyc + 3);

      // Multiply overflow, then a divide start clears the exception.
      start_op(1'b1, 1'b0, 32'd9, 32'h1234_5678, 1'b1);
      run_until(done_c + 1);
      start_op(1'b0, 1'b1, 32'd5, 32'd20, 1'b0);
      run_until(done_c + 1);

      // Divide aborted by a multiply at RUN iteration 10.
      start_op(1'b0, 1'b1, 32'd3, 32'd33, 1'b0);
      run_until(load_c + 11);
      start_op(1'b1, 1'b0, 32'd6, 32'd42, 1'b0);
      run_until(done_c + 2);

      // Reset at RUN iteration 5, then simultaneous MULT+DIV with B=0.
      start_op(1'b1, 1'b0, 32'd4, 32'd8, 1'b0);
      run_until(load_c + 6);
      do_reset(1);
      run_until(cyc + 40);
      start_op(1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
      run_until(done_c + 2);

      check_val("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
